pipeline_mod_sub: RTL and testbench

PIPELINE_MOD_SUB -- requirements
Module: pipeline_mod_sub

---
 rtl/pipeline_mod_sub_pkg.sv | 16 +
 rtl/pipeline_mod_sub_if.sv | 34 +++
 rtl/pipeline_mod_sub.sv | 128 ++++++++++++
 tb/tb_pipeline_mod_sub.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_mod_sub_pkg.sv
// pipeline_mod_sub shared types and widths.
// Word width, address width and FSM state encoding.
package pipeline_mod_sub_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int TOTAL_BITS = 256;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SUB   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pipeline_mod_sub_if.sv
// pipeline_mod_sub bus: start/count, operand reads,
// difference writes and completion status.
interface pipeline_mod_sub_if #(
  parameter int DATA_WIDTH = pipeline_mod_sub_pkg::DATA_WIDTH
);
  import pipeline_mod_sub_pkg::*;

  logic                  sub_start;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] s_word;
  logic [DATA_WIDTH-1:0] m_word;
  logic                  result_valid;
  logic [ADDR_WIDTH-1:0] result_addr;
  logic [DATA_WIDTH-1:0] result;
  logic                  sub_complete;
  logic                  sel_diff;

  modport master (
    input  sub_start, word_cnt, s_word, m_word,
    output read_en, read_addr, result_valid,
    output result_addr, result, sub_complete,
    output sel_diff
  );

  modport slave (
    output sub_start, word_cnt, s_word, m_word,
    input  read_en, read_addr, result_valid,
    input  result_addr, result, sub_complete,
    input  sel_diff
  );

endinterface

// File: rtl/pipeline_mod_sub.sv
// pipeline_mod_sub: multi-word S - M with rippled borrow,
// two-cycle read-to-write latency, sel_diff = (S >= M).
module pipeline_mod_sub #(
  parameter int DATA_WIDTH = pipeline_mod_sub_pkg::DATA_WIDTH
) (
  input  logic               CLK,
  input  logic               RST_N,
  pipeline_mod_sub_if.master bus
);
  import pipeline_mod_sub_pkg::*;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d;
  logic                  drain_q, drain_d;
  logic                  rd1_q, rd2_q;
  logic [ADDR_WIDTH-1:0] a1_q, a2_q;
  logic                  borrow_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  sel_q;
  logic [DATA_WIDTH:0]   diff;
  logic                  rd_en;
  logic                  go;
  logic                  zero_go;
  logic                  last1;
  logic [ADDR_WIDTH-1:0] n_m1;

  assign n_m1  = n_q - ADDR_WIDTH'(1);
  assign rd_en = (state_q == S_SUB);
  assign last1 = rd1_q && (a1_q == n_m1);

  assign diff = {1'b0, bus.s_word}
              - {1'b0, bus.m_word}
              - {{DATA_WIDTH{1'b0}}, borrow_q};

  // next-state, word counter and drain counter
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    drain_d = drain_q;
    go      = 1'b0;
    zero_go = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.sub_start) begin
          n_d = bus.word_cnt;
          k_d = '0;
          if (bus.word_cnt == '0) begin
            zero_go = 1'b1;
            state_d = S_DONE;
          end else begin
            go      = 1'b1;
            state_d = S_SUB;
          end
        end
      end
      S_SUB: begin
        if (k_q == n_m1) begin
          k_d     = '0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, latched count and counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  // read-to-write alignment, borrow chain, result and select
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd1_q    <= 1'b0;
      rd2_q    <= 1'b0;
      a1_q     <= '0;
      a2_q     <= '0;
      borrow_q <= 1'b0;
      res_q    <= '0;
      sel_q    <= 1'b0;
    end else begin
      rd1_q <= rd_en;
      rd2_q <= rd1_q;
      a1_q  <= k_q;
      a2_q  <= a1_q;
      if (go) begin
        borrow_q <= 1'b0;
      end else if (rd1_q) begin
        borrow_q <= diff[DATA_WIDTH];
      end
      if (rd1_q) res_q <= diff[DATA_WIDTH-1:0];
      if (zero_go) begin
        sel_q <= 1'b1;
      end else if (last1) begin
        sel_q <= ~diff[DATA_WIDTH];
      end
    end
  end

  assign bus.read_en      = rd_en;
  assign bus.read_addr    = k_q;
  assign bus.result_valid = rd2_q;
  assign bus.result_addr  = a2_q;
  assign bus.result       = res_q;
  assign bus.sub_complete = (state_q == S_DONE);
  assign bus.sel_diff     = sel_q;

endmodule

// File: tb/tb_pipeline_mod_sub.sv
// tb_pipeline_mod_sub: directed vectors for the
// multi-word subtractor with hand-computed results.
module tb_pipeline_mod_sub;

  logic CLK;
  logic RST_N;
  int   checks;
  int   failures;

  logic [31:0] s_mem [8];
  logic [31:0] m_mem [8];
  logic [31:0] d_exp [8];

  pipeline_mod_sub_if #(.DATA_WIDTH(32)) bus ();

  pipeline_mod_sub #(.DATA_WIDTH(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // operand buffers: one-cycle read latency
  always @(posedge CLK) begin
    if (bus.read_en) begin
      bus.s_word <= s_mem[bus.read_addr[2:0]];
      bus.m_word <= m_mem[bus.read_addr[2:0]];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ld(input int i, input logic [31:0] s,
                    input logic [31:0] m, input logic [31:0] d);
    s_mem[i] = s;
    m_mem[i] = m;
    d_exp[i] = d;
  endtask

  task automatic run(input int n, input logic exp_sel,
                     input string tag);
    int nrd;
    int nres;
    int last_rd;
    int done_c;
    int rdc [8];
    nrd = 0;
    nres = 0;
    last_rd = 0;
    done_c = 0;
    for (int i = 0; i < 8; i++) rdc[i] = 0;
    bus.sub_start = 1'b1;
    bus.word_cnt  = n;
    for (int c = 1; c <= 40 && done_c == 0; c++) begin
      @(negedge CLK);
      bus.sub_start = (c == 2 && n > 0);
      bus.word_cnt  = 32'd5;
      if (bus.read_en) begin
        chk({tag, "_raddr"}, bus.read_addr, nrd);
        if (nrd < 8) rdc[nrd] = c;
        last_rd = c;
        nrd++;
      end
      if (bus.result_valid) begin
        chk({tag, "_waddr"}, bus.result_addr, nres);
        if (nres < 8) begin
          chk({tag, "_data"}, bus.result, d_exp[nres]);
          chk({tag, "_lat"}, c, rdc[nres] + 2);
        end
        nres++;
      end
      if (bus.sub_complete) done_c = c;
    end
    chk({tag, "_done_seen"}, done_c != 0, 1);
    chk({tag, "_nreads"}, nrd, n);
    chk({tag, "_nwrites"}, nres, n);
    chk({tag, "_done_lat"}, done_c,
        (n == 0) ? 1 : last_rd + 3);
    chk({tag, "_sel"}, bus.sel_diff, exp_sel);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, bus.sub_complete, 0);
    chk({tag, "_sel_hold"}, bus.sel_diff, exp_sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int quiet;
    checks = 0;
    failures = 0;
    bus.sub_start = 1'b0;
    bus.word_cnt  = '0;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_read_en", bus.read_en, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_done", bus.sub_complete, 0);
    chk("rst_waddr", bus.result_addr, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_sel", bus.sel_diff, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    ld(0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002);
    run(1, 1'b1, "n1");

    ld(0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    ld(1, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000);
    run(2, 1'b1, "n2_borrow");

    ld(0, 32'h9ABC_DEF0, 32'h9ABC_DEF0, 32'h0000_0000);
    ld(1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000);
    run(2, 1'b1, "n2_equal");

    ld(0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
    ld(1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    ld(2, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002);
    ld(3, 32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFF0);
    run(4, 1'b0, "n4_lt");

    run(0, 1'b1, "n0");

    for (int i = 0; i < 8; i++) ld(i, 32'd10 + i, 32'd1, 32'd9 + i);
    bus.sub_start = 1'b1;
    bus.word_cnt  = 32'd8;
    @(negedge CLK);
    bus.sub_start = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (bus.read_en && bus.read_addr == 32'd2) found = 1;
      else @(negedge CLK);
    end
    chk("rst_mid_k2_seen", found, 1);
    chk("rst_mid_pre_valid", bus.result_valid, 1);
    #1 RST_N = 1'b0;
    @(negedge CLK);
    chk("rst_mid_read_en", bus.read_en, 0);
    chk("rst_mid_raddr", bus.read_addr, 0);
    chk("rst_mid_valid", bus.result_valid, 0);
    chk("rst_mid_waddr", bus.result_addr, 0);
    chk("rst_mid_result", bus.result, 0);
    chk("rst_mid_done", bus.sub_complete, 0);
    chk("rst_mid_sel", bus.sel_diff, 0);
    RST_N = 1'b1;
    quiet = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.result_valid || bus.sub_complete ||
          bus.read_en) quiet++;
    end
    chk("rst_mid_quiet", quiet, 0);

    ld(0, 32'h0000_0007, 32'h0000_0002, 32'h0000_0005);
    run(1, 1'b1, "post_rst_n1");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
